// File: rtl/l2_uram_rd_tile.sv
// Per-tile L2 URAM read stage: line storage with a write port, a fixed-latency
// read pipeline and a credit-protected output FIFO that absorbs backpressure.
module l2_uram_rd_tile #(
    parameter int l2_nstrms  = 16,
    parameter int l2_ncl     = 256,
    parameter int cl_width   = 512,
    parameter int rd_lat     = 2,
    parameter int fifo_depth = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_addr_v,
    output logic                         i_addr_r,
    input  logic [$clog2(l2_nstrms)-1:0] i_addr_sid,
    input  logic [$clog2(l2_ncl)-1:0]    i_addr_ptr,
    input  logic                         i_wr_v,
    input  logic [$clog2(l2_nstrms)-1:0] i_wr_sid,
    input  logic [$clog2(l2_ncl)-1:0]    i_wr_ptr,
    input  logic [cl_width-1:0]          i_wr_d,
    output logic                         o_rd_v,
    input  logic                         o_rd_r,
    output logic [$clog2(l2_nstrms)-1:0] o_rd_sid,
    output logic [cl_width-1:0]          o_rd_d
);

    localparam int SID_W  = $clog2(l2_nstrms);
    localparam int PTR_W  = $clog2(l2_ncl);
    localparam int ADDR_W = SID_W + PTR_W;
    localparam int NLINES = l2_nstrms * l2_ncl;
    localparam int CNT_W  = $clog2(fifo_depth + 1);
    localparam int FP_W   = $clog2(fifo_depth);

    // FIFO pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [FP_W-1:0] ptr_inc(input logic [FP_W-1:0] p);
        if (p == FP_W'(fifo_depth - 1))
            return '0;
        return p + FP_W'(1);
    endfunction

    logic [cl_width-1:0] r_mem [NLINES];

    logic                w_acc;
    logic                w_pop;
    logic                w_push;
    logic                w_fifo_v;
    logic [ADDR_W-1:0]   w_rd_addr;
    logic [ADDR_W-1:0]   w_wr_addr;

    logic                r_addr_r;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_next;

    logic [rd_lat-1:0]   r_vld_p;
    logic [SID_W-1:0]    r_sid_p [rd_lat];
    logic [cl_width-1:0] r_dat_p [rd_lat];

    logic [cl_width-1:0] r_fifo_d   [fifo_depth];
    logic [SID_W-1:0]    r_fifo_sid [fifo_depth];
    logic [FP_W-1:0]     r_wptr;
    logic [FP_W-1:0]     r_rptr;
    logic [CNT_W-1:0]    r_fcnt;

    assign w_rd_addr = {i_addr_sid, i_addr_ptr};
    assign w_wr_addr = {i_wr_sid, i_wr_ptr};
    assign w_acc     = i_addr_v & r_addr_r;
    assign w_fifo_v  = (r_fcnt != '0);
    assign w_pop     = w_fifo_v & o_rd_r;
    assign w_push    = r_vld_p[rd_lat-1];

    // Credits cover both in-flight and buffered lines, so a push always has room.
    always_comb begin
        w_cnt_next = r_cnt;
        if (w_acc && !w_pop)
            w_cnt_next = r_cnt + CNT_W'(1);
        else if (!w_acc && w_pop)
            w_cnt_next = r_cnt - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt    <= '0;
            r_addr_r <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_next;
            r_addr_r <= (w_cnt_next < CNT_W'(fifo_depth));
        end
    end

    // Stage p0: URAM read (read-first against a same-edge write), then delay stages.
    always_ff @(posedge clk) begin
        if (i_wr_v)
            r_mem[w_wr_addr] <= i_wr_d;
        r_dat_p[0] <= r_mem[w_rd_addr];
        r_sid_p[0] <= i_addr_sid;
        for (int s = 1; s < rd_lat; s++) begin
            r_dat_p[s] <= r_dat_p[s-1];
            r_sid_p[s] <= r_sid_p[s-1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vld_p <= '0;
        end else begin
            r_vld_p[0] <= w_acc;
            for (int s = 1; s < rd_lat; s++)
                r_vld_p[s] <= r_vld_p[s-1];
        end
    end

    // Pipeline output stage: unconditional push into the output FIFO.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_d[r_wptr]   <= r_dat_p[rd_lat-1];
            r_fifo_sid[r_wptr] <= r_sid_p[rd_lat-1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_fcnt <= '0;
        end else begin
            if (w_push)
                r_wptr <= ptr_inc(r_wptr);
            if (w_pop)
                r_rptr <= ptr_inc(r_rptr);
            case ({w_push, w_pop})
                2'b10:   r_fcnt <= r_fcnt + CNT_W'(1);
                2'b01:   r_fcnt <= r_fcnt - CNT_W'(1);
                default: r_fcnt <= r_fcnt;
            endcase
        end
    end

    // Outputs are forced to zero while empty so reset leaves them cleared.
    assign i_addr_r = r_addr_r;
    assign o_rd_v   = w_fifo_v;
    assign o_rd_sid = w_fifo_v ? r_fifo_sid[r_rptr] : '0;
    assign o_rd_d   = w_fifo_v ? r_fifo_d[r_rptr] : '0;

endmodule

// File: doc/l2_uram_rd_tile.md
# l2_uram_rd_tile

Per-tile L2 URAM read stage. It sits directly downstream of the L2 controller's per-tile address port (`o_addr_v/r/sid/ptr`) and is instantiated once per tile. It holds the tile's cache-line storage and accepts line writes from the OpenCAPI response data path. It returns read lines in request order through a credit-protected output FIFO, so backpressure never stalls the fixed-latency URAM pipeline.

## Interface
- `l2_nstrms`, 16, streams per tile
- `l2_ncl`, 256, cache lines per stream
- `cl_width`, 512, cache-line data width in bits
- `rd_lat`, 2, URAM read pipeline latency in cycles (≥1)
- `fifo_depth`, 4, output FIFO depth; must be ≥ `rd_lat`+2
- `clk` in 1: single clock, all logic on rising edge
- `reset` in 1: asynchronous, active-low reset
- `i_addr_v` in 1: read request valid
- `i_addr_r` out 1: read request ready
- `i_addr_sid` in $clog2(l2_nstrms): stream within the tile
- `i_addr_ptr` in $clog2(l2_ncl): line pointer within the stream
- `i_wr_v` in 1: line write strobe (no ready; always accepted)
- `i_wr_sid` in $clog2(l2_nstrms): write stream
- `i_wr_ptr` in $clog2(l2_ncl): write line pointer
- `i_wr_d` in cl_width: write data
- `o_rd_v` out 1: read data valid
- `o_rd_r` in 1: read data ready
- `o_rd_sid` out $clog2(l2_nstrms): stream of the returned line
- `o_rd_d` out cl_width: returned line

## Operation
- Storage: `l2_nstrms*l2_ncl` entries of `cl_width`, addressed `{sid, ptr}` (sid is the MSBs). Contents are not reset.
- Read accept: `i_addr_v & i_addr_r` at a rising edge. The address enters a `rd_lat`-stage pipeline. The sid travels alongside in a matching valid/sid shift register.
- Write: `i_wr_v` at a rising edge writes `i_wr_d` to `{i_wr_sid, i_wr_ptr}`.
- Read/write collision (same address, same edge): the read returns the old data (read-first). The new data is visible to reads accepted at any later edge.
- Pipeline output is pushed unconditionally into the output FIFO (depth `fifo_depth`). The FIFO head drives `o_rd_v/o_rd_sid/o_rd_d`. A pop occurs on `o_rd_v & o_rd_r`.
- Credit counter `cnt` (width $clog2(fifo_depth+1)) tracks in-flight plus buffered lines:
  - accept only: +1
  - pop only: −1
  - accept and pop on the same edge: unchanged
- `i_addr_r` is registered: next value = (`cnt_next` < `fifo_depth`). Because of this, the FIFO can never overflow and the pipeline never stalls.
- Ordering: responses leave strictly in acceptance order, independent of sid.
- Reset (reset=0, asynchronous):
  - `i_addr_r`=0, `o_rd_v`=0, `o_rd_sid`=0, `o_rd_d`=0
  - `cnt`=0, FIFO empty, pipeline valids cleared
  - In-flight reads are discarded; stored lines are kept.
- When reset deasserts mid-operation, the block restarts empty. No stale read is ever presented.

## Timing
- `i_addr_r` rises on the first rising edge after reset deasserts.
- Read latency: accepted at edge k, the line is in the FIFO at edge k+`rd_lat`. `o_rd_v`=1 in the cycle following edge k+`rd_lat`, so the earliest pop is edge k+`rd_lat`+1.
- Throughput: with `o_rd_r`=1, one read per cycle is sustained indefinitely (requires `fifo_depth` ≥ `rd_lat`+2).
- Full: when `cnt` reaches `fifo_depth`, `i_addr_r`=0 from the next cycle. It returns to 1 the cycle after the first pop.
- Empty: `o_rd_v`=0; the values on `o_rd_sid/o_rd_d` carry no meaning.
- FIFO pointers wrap modulo `fifo_depth` (any depth ≥ `rd_lat`+2, not only powers of two).
- Once `o_rd_v` is asserted, it and its data stay stable until popped.

## Test plan
- Reset/idle: hold reset=0 for 10 cycles, then release.
  - During reset: `i_addr_r`=0, `o_rd_v`=0.
  - `i_addr_r`=1 after the first edge following release.
  - `o_rd_v` stays 0 with no requests.
- Write-then-read latency: write 0xA5…A5 to sid 1 ptr 3, then read sid 1 ptr 3.
  - `o_rd_v` rises exactly `rd_lat`+1 cycles after the accept edge, with sid=1 and data 0xA5…A5.
- Collision: write 0x1111… to sid 2 ptr 0 while a read of sid 2 ptr 0 is accepted on the same edge (old content 0x2222…), then read again.
  - First read returns 0x2222…; second read returns 0x1111….
- Backpressure/full: hold `o_rd_r`=0 and offer 8 back-to-back reads of sids 0–7.
  - Exactly `fifo_depth`=4 are accepted and `i_addr_r` drops.
  - Raise `o_rd_r`: sids 0–7 come out in order and none is lost or duplicated.
- Streaming: with `o_rd_r`=1, issue 64 consecutive reads (ptr 0–63, sid = ptr mod 16).
  - `i_addr_r` never drops and `o_rd_v` stays high for 64 consecutive cycles.
  - Data matches the preloaded pattern.
- Mid-operation reset: with 3 reads in flight and 1 buffered, pulse reset low between edges.
  - `o_rd_v` drops immediately, and `cnt` and the FIFO clear.
  - After release, a new read returns correct preserved data, and no stale response appears.
